div_share_arbiter: RTL and testbench

//  Shares one iterative divider (Divide: 4 en-cycles per op, fin on 4th) among N_REQ requesters
//  in the QR datapath (column normalisation, Givens ratios). Round-robin grant, operand capture,

---
 rtl/div_share_arbiter_if.sv | 29 ++
 rtl/div_share_arbiter.sv | 99 +++++++++
 tb/tb_div_share_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/div_share_arbiter_if.sv
// div_share_arbiter_if: request, response and divider-side signals of the shared divider arbiter
interface div_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    i_req_valid;
  logic [16*N_REQ-1:0] i_req_a;
  logic [16*N_REQ-1:0] i_req_b;
  logic [N_REQ-1:0]    o_req_ready;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [ID_W-1:0]     o_rsp_id;
  logic [15:0]         o_rsp_data;
  logic                o_rsp_dz;
  logic [15:0]         o_div_a;
  logic [15:0]         o_div_b;
  logic                o_div_en;
  logic                i_div_fin;
  logic [15:0]         i_div_result;
  logic                o_busy;
  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_rsp_ready, i_div_fin, i_div_result,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_dz, o_div_a, o_div_b, o_div_en, o_busy
  );
  modport master (
    output i_req_valid, i_req_a, i_req_b, i_rsp_ready, i_div_fin, i_div_result,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_dz, o_div_a, o_div_b, o_div_en, o_busy
  );
endinterface

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one 4-cycle divider with divide-by-zero bypass and response buffer
module div_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic i_clk,
  input logic i_rst,
  div_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, ZERO} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, win, cand;
  logic [15:0] a_q, a_d, b_q, b_d, sat_q, sat_d, win_a, win_b;
  logic rsp_valid_q, rsp_valid_d, rsp_dz_q, rsp_dz_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic found, can_grant, hs, fill;
  // first valid requester after the round-robin pointer, wrapping
  always_comb begin
    win = rr_q;
    cand = rr_q;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(rr_q) + i) % N_REQ);
      if (!found && bus.i_req_valid[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  assign can_grant = (state_q == IDLE) && (!rsp_valid_q || bus.i_rsp_ready);
  assign hs = can_grant && found;
  assign win_a = bus.i_req_a[16*win +: 16];
  assign win_b = bus.i_req_b[16*win +: 16];
  assign bus.o_req_ready = hs ? (N_REQ'(1) << win) : '0;
  // FSM next state, operand capture and saturation value for the zero-divisor bypass
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    sat_d = sat_q;
    fill = 1'b0;
    if (hs) begin
      rr_d = win;
      id_d = win;
      state_d = (win_b == 16'h0000) ? ZERO : DIV;
      sat_d = (win_a == 16'h0000) ? 16'h0000 : win_a[15] ? 16'h8000 : 16'h7FFF;
      a_d = (win_b == 16'h0000) ? a_q : win_a;
      b_d = (win_b == 16'h0000) ? b_q : win_b;
    end
    if (state_q == ZERO || (state_q == DIV && bus.i_div_fin)) begin
      state_d = IDLE;
      fill = 1'b1;
    end
  end
  // single-entry response buffer: fill wins over pop so a same-cycle pop+fill stays valid
  always_comb begin
    rsp_valid_d = fill || (rsp_valid_q && !bus.i_rsp_ready);
    rsp_id_d = fill ? id_q : rsp_id_q;
    rsp_data_d = fill ? ((state_q == ZERO) ? sat_q : bus.i_div_result) : rsp_data_q;
    rsp_dz_d = fill ? (state_q == ZERO) : rsp_dz_q;
  end
  // state registers; reset drops any job in flight and points rr so requester 0 wins first
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q <= ID_W'(N_REQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sat_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      rsp_dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      sat_q <= sat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_dz_q <= rsp_dz_d;
    end
  end
  assign bus.o_div_en = (state_q == DIV);
  assign bus.o_div_a = a_q;
  assign bus.o_div_b = b_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_id = rsp_id_q;
  assign bus.o_rsp_data = rsp_data_q;
  assign bus.o_rsp_dz = rsp_dz_q;
  assign bus.o_busy = (state_q != IDLE) || rsp_valid_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: randomized and directed scoreboard bench for the shared divider arbiter
module tb_div_share_arbiter;
  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        dz;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  div_share_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();
  div_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] div_fn(input logic [15:0] a, input logic [15:0] b);
    return a ^ {b[7:0], b[15:8]} ^ 16'h1234;
  endfunction
  logic [1:0] scnt;
  always @(posedge clk or posedge rst)
    if (rst) scnt <= 2'd0;
    else if (bus.o_div_en) scnt <= scnt + 2'd1;
  assign bus.i_div_fin = bus.o_div_en && scnt == 2'd3;
  assign bus.i_div_result = div_fn(bus.o_div_a, bus.o_div_b);
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", n, got, exp, cyc);
    end
  endtask
  rsp_t sb[$];
  logic [3:0] granted;
  int m_rr, idle_at, done_at, ds;
  bit pend, buf_full;
  logic [15:0] exp_da, exp_db;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_dz,
          bus.o_div_a, bus.o_div_b, bus.o_div_en, bus.o_busy}, 64'd0);
      m_rr = 3; idle_at = 0; done_at = 0; ds = -10; pend = 0; buf_full = 0;
      exp_da = 16'h0; exp_db = 16'h0; granted = 4'h0;
      sb.delete();
    end else begin
      logic [3:0] exp_rdy;
      int w;
      bit nb;
      exp_rdy = 4'h0;
      w = -1;
      if (cyc >= idle_at && (!buf_full || bus.i_rsp_ready))
        for (int i = 1; i <= 4; i++)
          if (w < 0 && bus.i_req_valid[(m_rr + i) % 4]) w = (m_rr + i) % 4;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", bus.o_req_ready, exp_rdy);
      chk("rsp_valid", bus.o_rsp_valid, buf_full);
      chk("div_en", bus.o_div_en, cyc >= ds && cyc < ds + 4);
      chk("div_a", bus.o_div_a, exp_da);
      chk("div_b", bus.o_div_b, exp_db);
      chk("busy", bus.o_busy, cyc < idle_at || buf_full);
      granted = exp_rdy;
      nb = buf_full && !bus.i_rsp_ready;
      if (pend && done_at == cyc + 1) begin
        nb = 1;
        pend = 0;
      end
      buf_full = nb;
      if (w >= 0) begin
        logic [15:0] a, b;
        rsp_t r;
        a = bus.i_req_a[16*w +: 16];
        b = bus.i_req_b[16*w +: 16];
        m_rr = w;
        r.id = 2'(w);
        pend = 1;
        if (b == 16'h0) begin
          r.data = (a == 16'h0) ? 16'h0000 : (a[15] ? 16'h8000 : 16'h7FFF);
          r.dz = 1'b1;
          done_at = cyc + 2;
        end else begin
          r.data = div_fn(a, b);
          r.dz = 1'b0;
          done_at = cyc + 5;
          ds = cyc + 1;
          exp_da = a;
          exp_db = b;
        end
        idle_at = done_at;
        sb.push_back(r);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && bus.o_rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected got id=%0d data=%h dz=%b exp=none", bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_dz);
      end else begin
        chk("rsp_contents", {bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_dz}, sb[0]);
        if (bus.i_rsp_ready) void'(sb.pop_front());
      end
    end
  end
  int rate = 0;
  int rsp_mode = 0;
  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
    bus.i_req_valid[k] = 1'b1;
    bus.i_req_a[16*k +: 16] = a;
    bus.i_req_b[16*k +: 16] = b;
  endtask
  task automatic rand_op(input int k);
    logic [15:0] a, b;
    a = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
    b = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
    set_op(k, a, b);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (granted[k]) bus.i_req_valid[k] = 1'b0;
      if (!bus.i_req_valid[k] && int'($urandom_range(99)) < rate) rand_op(k);
    end
    bus.i_rsp_ready = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 2) ? 1'b0 : 1'($urandom_range(1));
  endtask
  initial begin
    logic [15:0] zv [3];
    zv[0] = 16'h0100; zv[1] = 16'hFF00; zv[2] = 16'h0000;
    bus.i_req_valid = '0;
    bus.i_req_a = '0;
    bus.i_req_b = '0;
    bus.i_rsp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    set_op(1, 16'h2000, 16'h4000);
    repeat (12) step();
    for (int k = 0; k < 4; k++) rand_op(k);
    for (int k = 0; k < 4; k++) bus.i_req_b[16*k +: 16] = 16'h0101 + 16'(k);
    rate = 100;
    repeat (30) step();
    rate = 0;
    repeat (25) step();
    for (int i = 0; i < 3; i++) begin
      set_op(0, zv[i], 16'h0000);
      repeat (5) step();
    end
    rsp_mode = 2;
    step();
    set_op(0, 16'h1111, 16'h2222);
    step();
    set_op(2, 16'h3333, 16'h4444);
    repeat (15) step();
    rsp_mode = 0;
    repeat (10) step();
    set_op(0, 16'h5555, 16'h0666);
    for (int i = 0; i < 20 && cyc != ds + 2; i++) step();
    chk("rst_wait_div3", cyc == ds + 2, 1'b1);
    rst = 1'b1;
    bus.i_req_valid = '0;
    step();
    rst = 1'b0;
    set_op(0, 16'h7001, 16'h0203);
    repeat (10) step();
    rate = 30;
    rsp_mode = 1;
    repeat (2000) step();
    rsp_mode = 0;
    repeat (1000) step();
    rate = 0;
    repeat (40) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
